// File: rtl/lifo_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing one LIFO.
// Serialises push/pop transactions, drives the LIFO strobes, and returns pop data and error status.
module lifo_arbiter #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              op0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              op1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              lifo_we,
    output logic              lifo_re,
    output logic [DATA_W-1:0] lifo_din,
    input  logic [DATA_W-1:0] lifo_dout,
    input  logic              lifo_full,
    input  logic              lifo_empty
);

    typedef enum logic [2:0] {IDLE, PUSH, POP, POP_WAIT, ACK} state_t;

    state_t            state_q, state_d;
    logic              pri_q, pri_d;
    logic              g_q, g_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              sel_op;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        state_d  = state_q;
        pri_d    = pri_q;
        g_d      = g_q;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        we_d     = 1'b0;
        re_d     = 1'b0;
        din_d    = din_q;
        sel_op   = 1'b0;
        sel_data = '0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    g_d      = (req0 && req1) ? pri_q : req1;
                    sel_op   = g_d ? op1 : op0;
                    sel_data = g_d ? wdata1 : wdata0;
                    if (!sel_op) begin
                        if (lifo_full) begin
                            state_d = ACK;
                            err_d   = 1'b1;
                        end else begin
                            state_d = PUSH;
                            we_d    = 1'b1;
                            din_d   = sel_data;
                        end
                    end else begin
                        if (lifo_empty) begin
                            state_d = ACK;
                            err_d   = 1'b1;
                        end else begin
                            state_d = POP;
                            re_d    = 1'b1;
                        end
                    end
                end
            end
            PUSH:     state_d = ACK;
            POP:      state_d = POP_WAIT;
            POP_WAIT: begin
                rdata_d = lifo_dout;
                state_d = ACK;
            end
            ACK: begin
                pri_d   = ~g_q;
                state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase

        // Acks are registered on entry to ACK so the pulse coincides with the ACK state.
        ack0_d = (state_d == ACK) && !g_d;
        ack1_d = (state_d == ACK) &&  g_d;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pri_q   <= 1'b0;
            g_q     <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
            g_q     <= g_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            re_q    <= re_d;
            din_q   <= din_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign lifo_we  = we_q;
    assign lifo_re  = re_q;
    assign lifo_din = din_q;

endmodule

// File: doc/lifo_arbiter.md
Name: lifo_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for a shared 8-bit LIFO (stack) with ports we/re/data_in/data_out/full/empty.
- Each requester issues push or pop transactions. The arbiter serialises them, drives the LIFO strobes, and returns pop data and error status.
- Sits between requester logic and the single LIFO instance. Exactly one LIFO operation is in flight at any time.

Parameters:
- DATA_W, 8, width of push/pop data; must match LIFO data width.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req0  in  1  requester 0 transaction request (level, held until ack0)
- op0  in  1  requester 0 op: 0 = push, 1 = pop
- wdata0  in  DATA_W  requester 0 push data
- req1  in  1  requester 1 request
- op1  in  1  requester 1 op
- wdata1  in  DATA_W  requester 1 push data
- ack0  out  1  one-cycle completion pulse to requester 0
- ack1  out  1  one-cycle completion pulse to requester 1
- err  out  1  valid with ack: 1 = push rejected (full) or pop rejected (empty)
- rdata  out  DATA_W  pop result, valid with ack when op = pop and err = 0
- busy  out  1  1 whenever state != IDLE
- lifo_we  out  1  LIFO write strobe
- lifo_re  out  1  LIFO read strobe
- lifo_din  out  DATA_W  LIFO write data
- lifo_dout  in  DATA_W  LIFO read data, registered, valid the cycle after the re edge
- lifo_full  in  1  LIFO full flag
- lifo_empty  in  1  LIFO empty flag

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE; priority pointer pri = 0.
  - All outputs 0: ack0, ack1, err, rdata, busy, lifo_we, lifo_re, lifo_din.
  - An in-flight transaction is abandoned with no ack. The LIFO shares the same reset.
- All outputs are registered.
- States: IDLE, PUSH, POP, POP_WAIT, ACK.
- IDLE, grant selection:
  - Only one req high: grant g = that requester.
  - Both high: g = pri.
  - None high: stay in IDLE.
  - On grant, latch g, op, and wdata, then take the first matching branch below.
- IDLE, push branches:
  - Push with lifo_full = 1: go to ACK with err = 1. No strobe.
  - Push, not full: go to PUSH with lifo_we = 1 and lifo_din = wdata_g.
- IDLE, pop branches:
  - Pop with lifo_empty = 1: go to ACK with err = 1. No strobe.
  - Pop, not empty: go to POP with lifo_re = 1.
- PUSH: lifo_we <= 0; go to ACK with err = 0.
- POP: lifo_re <= 0; go to POP_WAIT.
- POP_WAIT: rdata <= lifo_dout; go to ACK with err = 0.
- ACK:
  - ack_g = 1 for exactly this cycle, with err valid.
  - rdata holds its last value outside pop acks.
  - pri <= ~g, including after error transactions.
  - Next state is IDLE.
- Latency, counted from the edge that samples req in IDLE:
  - Push: ack high after edge +2.
  - Pop: ack high after edge +3.
  - Error: ack high after edge +1.
- Requester protocol:
  - Drop req, or change op/data, during the ack cycle.
  - A req still high when IDLE is re-entered is treated as a new transaction.
- Strobes:
  - lifo_we and lifo_re are never high together.
  - Each strobe is high for exactly one cycle per accepted transaction.
- Full and empty are sampled only in IDLE. They are stable because only one operation is in flight.
- Changes to req or op of the non-granted requester mid-transaction have no effect until IDLE.

Test Plan:
- Reset, then req0 pushes 8'h11, 8'h22, 8'h33 in turn:
  - Each push yields a 1-cycle lifo_we with lifo_din equal to the data.
  - ack0 follows 2 cycles after the sampled req; err = 0.
- Then req1 pops 3 times:
  - rdata = 8'h33, 8'h22, 8'h11 in order, each with ack1 and err = 0.
  - Each ack is 3 cycles after the sampled req; lifo_re is a 1-cycle pulse.
- Pop on an empty LIFO (lifo_empty = 1):
  - ack high 1 cycle after the sampled req with err = 1.
  - lifo_re never asserted; rdata unchanged.
- Fill the LIFO to full, then push 8'hAA:
  - ack with err = 1 and no lifo_we.
  - A following pop returns the previous top, not 8'hAA.
- req0 and req1 both held high with pushes 8'h01 and 8'h02 after reset:
  - Grant order is 0, 1, 0, 1 (ack0 and ack1 alternate).
  - lifo_din sequence is 01, 02, 01, 02.
- Assert rst low during POP_WAIT:
  - All outputs go 0 immediately; no ack is produced.
  - After release, busy = 0 and a new push completes normally.
